// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: walks pc through instruction memory, applying jump/branch
// redirects and downstream stalls. Define PC_MISALIGN_TRAP_EN to trap on misaligned targets.
//   state | meaning
//   BOOT  | one idle cycle after reset, no request
//   FETCH | requesting pc, waiting for imem_ack
//   HOLD  | fetch accepted under stall, next pc parked in pend_q
//   TRAP  | misaligned target taken, frozen until reset
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] goToAddress,
  input  logic        isJump,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        stall,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic [31:0] fetch_count,
  output logic        trap
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, TRAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        trap_q, trap_d;

  logic        accept;
  logic        misalign;
  logic [31:0] sel_pc;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;
  assign accept   = (state_q == FETCH) && imem_ack;

  always_comb begin
    sel_pc = pc_plus4;
    if (isJump)
      sel_pc = goToAddress;
    else if (branch_taken)
      sel_pc = pc_plus4 + (branch_offset << 2);
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign next_pc  = sel_pc;
  assign misalign = |sel_pc[1:0];
`else
  // Without the trap feature a misaligned target is silently word-aligned.
  assign next_pc  = sel_pc & ~32'h3;
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    trap_d  = trap_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (accept) begin
          cnt_d = cnt_q + 32'd1;
          if (misalign) begin
            pc_d    = next_pc;
            trap_d  = 1'b1;
            state_d = TRAP;
          end else if (stall) begin
            pend_d  = next_pc;
            state_d = HOLD;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          pc_d    = pend_q;
          state_d = FETCH;
        end
      end
      default: state_d = state_q;
    endcase
    req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      cnt_q   <= 32'd0;
      req_q   <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      trap_q  <= trap_d;
    end
  end

  assign imem_req    = req_q;
  assign pc          = pc_q;
  assign fetch_count = cnt_q;
  assign instr_valid = accept;
  assign trap        = trap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: accepted fetches are checked by a monitor against
// hand-computed {pc, fetch_count} pairs; state and boundary behaviour is checked directly.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] goToAddress;
  logic        isJump;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        stall;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic [31:0] fetch_count;
  logic        trap;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .goToAddress(goToAddress), .isJump(isJump),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .stall(stall),
    .imem_ack(imem_ack), .imem_req(imem_req), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .fetch_count(fetch_count), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every accepted fetch must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: got pc %h count %h expected no fetch", pc, fetch_count);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("acc_pc", pc, e[63:32]);
        chk("acc_count", fetch_count, e[31:0]);
      end
    end
  end

  // Called at posedge+1 with the DUT in FETCH; returns at the following posedge+1.
  task automatic accept(input logic [31:0] epc, input logic [31:0] ecnt, input logic j,
                        input logic [31:0] g, input logic b, input logic [31:0] o,
                        input logic s);
    exp_q.push_back({epc, ecnt});
    isJump = j; goToAddress = g; branch_taken = b; branch_offset = o; stall = s;
    imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0; isJump = 1'b0; branch_taken = 1'b0;
    goToAddress = 32'h0; branch_offset = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; goToAddress = 32'h0; isJump = 1'b0; branch_taken = 1'b0;
    branch_offset = 32'h0; stall = 1'b0; imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_trap", {31'h0, trap}, 32'h0);

    // Sequential run with imem_ack tied high, jump+branch together at pc 0x10.
    exp_q.push_back({32'h0,  32'd0});
    exp_q.push_back({32'h4,  32'd1});
    exp_q.push_back({32'h8,  32'd2});
    exp_q.push_back({32'hC,  32'd3});
    exp_q.push_back({32'h10, 32'd4});
    @(posedge clk); #1;
    rst_n = 1'b1; imem_ack = 1'b1;
    @(negedge clk);
    chk("boot_req", {31'h0, imem_req}, 32'h0);
    chk("boot_pc", pc, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    isJump = 1'b1; goToAddress = 32'h400; branch_taken = 1'b1; branch_offset = 32'd3;
    @(posedge clk); #1;
    isJump = 1'b0; goToAddress = 32'h0; branch_taken = 1'b0; branch_offset = 32'h0;
    imem_ack = 1'b0;
    @(negedge clk);
    chk("jump_prio_pc", pc, 32'h400);
    chk("jump_prio_count", fetch_count, 32'd5);
    chk("fetch_req", {31'h0, imem_req}, 32'h1);
    chk("noack_valid", {31'h0, instr_valid}, 32'h0);
    chk("pc_plus4", pc_plus4, 32'h404);

    // Backward branch.
    @(posedge clk); #1;
    accept(32'h400, 32'd5, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
    accept(32'h20,  32'd6, 1'b0, 32'h0,  1'b1, 32'hFFFF_FFFE, 1'b0);
    @(negedge clk);
    chk("branch_back_pc", pc, 32'h1C);

    // Accept under stall, then HOLD with redirect noise and ack high.
    @(posedge clk); #1;
    accept(32'h1C, 32'd7, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    accept(32'h40, 32'd8, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    imem_ack = 1'b1; isJump = 1'b1; goToAddress = 32'h9990_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_pc", pc, 32'h40);
      chk("hold_req", {31'h0, imem_req}, 32'h0);
      chk("hold_valid", {31'h0, instr_valid}, 32'h0);
      @(posedge clk); #1;
    end
    stall = 1'b0; imem_ack = 1'b0; isJump = 1'b0; goToAddress = 32'h0;
    @(negedge clk);
    chk("hold_count", fetch_count, 32'd9);
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_pc", pc, 32'h80);
    chk("release_req", {31'h0, imem_req}, 32'h1);
    chk("release_count", fetch_count, 32'd9);

    // Stall without ack has no effect.
    @(posedge clk); #1;
    stall = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("stall_noack_pc", pc, 32'h80);
    chk("stall_noack_req", {31'h0, imem_req}, 32'h1);
    @(posedge clk); #1;
    stall = 1'b0;

    // Sequential wrap at the top of the address space.
    accept(32'h80,        32'd9,  1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    accept(32'hFFFF_FFFC, 32'd10, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("wrap_pc", pc, 32'h0);

    // Reset in HOLD discards the pending redirect.
    @(posedge clk); #1;
    accept(32'h0,   32'd11, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    accept(32'h200, 32'd12, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("hold2_pc", pc, 32'h200);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_count", fetch_count, 32'h0);
    chk("async_rst_req", {31'h0, imem_req}, 32'h0);
    stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot2_req", {31'h0, imem_req}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("refetch_pc", pc, 32'h0);
    chk("refetch_req", {31'h0, imem_req}, 32'h1);

    // Misaligned jump target.
    @(posedge clk); #1;
    accept(32'h0, 32'd0, 1'b1, 32'h102, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_pc", pc, 32'h102);
    chk("mis_trap", {31'h0, trap}, 32'h1);
    chk("mis_req", {31'h0, imem_req}, 32'h0);
    @(posedge clk); #1;
    imem_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("trap_pc", pc, 32'h102);
    chk("trap_req", {31'h0, imem_req}, 32'h0);
    chk("trap_count", fetch_count, 32'd1);
    chk("trap_held", {31'h0, trap}, 32'h1);
    imem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("trap_rst", {31'h0, trap}, 32'h0);
    chk("trap_rst_pc", pc, 32'h0);
`else
    chk("mis_pc", pc, 32'h100);
    chk("mis_trap", {31'h0, trap}, 32'h0);
    chk("mis_req", {31'h0, imem_req}, 32'h1);
    chk("mis_count", fetch_count, 32'd1);
`endif

    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
